ddr_bank_timing_tracker: RTL and testbench

- Per-bank DRAM state and timing-constraint tracker that sits between the command scheduler and the DFI command path.
- Generalises the controller's fixed global timing constants and bank-state encoding into a module with parametrised bank count, row width and timing.
- Tracks the state and open row of each bank and runs per-bank and global timers (tRCD, tRP, tRAS, tRC, tRRD, tFAW, tCCD, tWTR, tWR, tRTP, tRFC).
- Gives the scheduler per-bank legality flags and flags every illegal command it is given.

---
 rtl/ddr_bank_timing_tracker.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ddr_bank_timing_tracker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_bank_timing_tracker.sv
// Per-bank DRAM state and timing-constraint tracker.
// Sits between the command scheduler and the DFI command path: it keeps the
// state and open row of every bank, runs per-bank and global timers, exposes
// per-bank legality flags, and flags and counts every illegal command.
//
// Timer convention: a command accepted at edge T loads tX-1, the dependent
// command is legal once the counter reads 0 (cycle T+tX), counters hold at 0.

// ---------------------------------------------------------------------------
// Per-bank context: state machine, open row and same-bank timers.
// ---------------------------------------------------------------------------
module ddr_bank_ctx #(
    parameter int ROW_W = 17,
    parameter int TW    = 7,
    parameter int T_RCD = 18,
    parameter int T_RP  = 18,
    parameter int T_RAS = 42,
    parameter int T_RC  = 60,
    parameter int T_CCD = 4,
    parameter int T_WR  = 15,
    parameter int T_RTP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             do_act,
    input  logic             do_rd,
    input  logic             do_wr,
    input  logic             do_pre,
    input  logic [ROW_W-1:0] row,
    output logic [2:0]       state,
    output logic [ROW_W-1:0] open_row,
    output logic             act_rdy,
    output logic             pre_rdy,
    output logic             is_open,
    output logic             is_idle,
    output logic             is_actg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_ACTG = 3'b001,
        S_ACTV = 3'b010,
        S_RD   = 3'b011,
        S_WR   = 3'b100,
        S_PRE  = 3'b101
    } bank_st_e;

    localparam logic [TW-1:0] L_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] L_RP  = TW'(T_RP - 1);
    localparam logic [TW-1:0] L_RAS = TW'(T_RAS - 1);
    localparam logic [TW-1:0] L_RC  = TW'(T_RC - 1);
    localparam logic [TW-1:0] L_CCD = TW'(T_CCD - 1);
    localparam logic [TW-1:0] L_WR  = TW'(T_WR - 1);
    localparam logic [TW-1:0] L_RTP = TW'(T_RTP - 1);
    localparam logic [TW-1:0] ONE   = TW'(1);

    bank_st_e        st, st_nxt;
    logic [TW-1:0]   trcd, trp, tras, trc, trtp, twr, burst;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] c);
        return (c != '0) ? c - ONE : '0;
    endfunction

    // Bank state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= st_nxt;
    end

    // Next state. Intermediate states leave on the edge where their timer
    // reaches 0; a one-cycle timing skips the intermediate state entirely so
    // the follow-up command is still legal at T+1.
    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE: if (do_act) st_nxt = (T_RCD == 1) ? S_ACTV : S_ACTG;
            S_ACTG: if (trcd <= ONE) st_nxt = S_ACTV;
            S_ACTV, S_RD, S_WR: begin
                if (do_pre)      st_nxt = (T_RP == 1) ? S_IDLE : S_PRE;
                else if (do_rd)  st_nxt = S_RD;
                else if (do_wr)  st_nxt = S_WR;
                else if (st != S_ACTV && burst <= ONE) st_nxt = S_ACTV;
            end
            S_PRE:  if (trp <= ONE) st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    // Same-bank readiness derived from state and timers
    always_comb begin
        is_open = (st == S_ACTV) || (st == S_RD) || (st == S_WR);
        is_idle = (st == S_IDLE);
        is_actg = (st == S_ACTG);
        act_rdy = is_idle && (trc == '0);
        pre_rdy = is_open && (tras == '0) && (trtp == '0) && (twr == '0);
    end

    // Same-bank timers and open row; a load beats the decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trcd     <= '0;
            trp      <= '0;
            tras     <= '0;
            trc      <= '0;
            trtp     <= '0;
            twr      <= '0;
            burst    <= '0;
            open_row <= '0;
        end else begin
            trcd  <= dec(trcd);
            trp   <= dec(trp);
            tras  <= dec(tras);
            trc   <= dec(trc);
            trtp  <= dec(trtp);
            twr   <= dec(twr);
            burst <= dec(burst);
            if (do_act) begin
                trcd     <= L_RCD;
                tras     <= L_RAS;
                trc      <= L_RC;
                open_row <= row;
            end
            if (do_rd) begin
                trtp  <= L_RTP;
                burst <= L_CCD;
            end
            if (do_wr) begin
                twr   <= L_WR;
                burst <= L_CCD;
            end
            if (do_pre) trp <= L_RP;
        end
    end

    assign state = st;

endmodule

// ---------------------------------------------------------------------------
// Top: command decode, global timers, legality and violation reporting.
// ---------------------------------------------------------------------------
module ddr_bank_timing_tracker #(
    parameter int NUM_BANKS = 8,
    parameter int ROW_W     = 17,
    parameter int T_RCD     = 18,
    parameter int T_RP      = 18,
    parameter int T_RAS     = 42,
    parameter int T_RC      = 60,
    parameter int T_RRD     = 8,
    parameter int T_FAW     = 40,
    parameter int T_CCD     = 4,
    parameter int T_WTR     = 8,
    parameter int T_WR      = 15,
    parameter int T_RTP     = 8,
    parameter int T_RFC     = 120,
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [3:0]                 cmd_type,
    input  logic [BW-1:0]              cmd_bank,
    input  logic [ROW_W-1:0]           cmd_row,
    output logic                       cmd_legal,
    output logic [3*NUM_BANKS-1:0]     bank_state_o,
    output logic [ROW_W*NUM_BANKS-1:0] open_row_o,
    output logic [NUM_BANKS-1:0]       act_ok,
    output logic [NUM_BANKS-1:0]       rd_ok,
    output logic [NUM_BANKS-1:0]       wr_ok,
    output logic [NUM_BANKS-1:0]       pre_ok,
    output logic                       ref_ok,
    output logic                       viol_o,
    output logic [15:0]                viol_count
);

    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DES  = 4'b1000;
    localparam logic [3:0] C_PREA = 4'b1010;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timers hold at most tX-1, so the widest constraint sets the width
    localparam int TMAX = mx(mx(mx(T_RCD, T_RP), mx(T_RAS, T_RC)),
                             mx(mx(mx(T_RRD, T_FAW), mx(T_CCD, T_WTR)),
                                mx(mx(T_WR, T_RTP), T_RFC)));
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0] L_RRD = TW'(T_RRD - 1);
    localparam logic [TW-1:0] L_FAW = TW'(T_FAW - 1);
    localparam logic [TW-1:0] L_CCD = TW'(T_CCD - 1);
    localparam logic [TW-1:0] L_WTR = TW'(T_WTR - 1);
    localparam logic [TW-1:0] L_RFC = TW'(T_RFC - 1);
    localparam logic [TW-1:0] ONE   = TW'(1);

    logic [TW-1:0]         trrd, tccd, twtr, trfc;
    logic [3:0][TW-1:0]    tfaw;
    logic [3:0]            faw_zero;
    logic [1:0]            faw_slot;

    logic [NUM_BANKS-1:0]  act_rdy, pre_rdy, is_open, is_idle, is_actg;
    logic [NUM_BANKS-1:0]  sel, do_act, do_rd, do_wr, do_pre;
    logic                  act_glob, rd_glob, wr_glob, prea_ok;
    logic                  bank_ok, legal, acc, bad;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] c);
        return (c != '0) ? c - ONE : '0;
    endfunction

    // Free tFAW slots and the lowest-index one an ACT will occupy
    always_comb begin
        faw_slot = 2'd0;
        for (int s = 0; s < 4; s++) faw_zero[s] = (tfaw[s] == '0);
        for (int s = 3; s >= 0; s--) if (faw_zero[s]) faw_slot = 2'(s);
    end

    // Global gating terms shared by every bank
    always_comb begin
        act_glob = (trrd == '0) && (|faw_zero) && (trfc == '0);
        rd_glob  = (tccd == '0) && (twtr == '0);
        wr_glob  = (tccd == '0);
        ref_ok   = (&is_idle) && (trfc == '0);
        // IDLE/PRECHARGE banks are skipped; any ACTIVATING bank blocks PREA
        prea_ok  = !(|is_actg) && (&(~is_open | pre_rdy));
    end

    assign act_ok = act_rdy & {NUM_BANKS{act_glob}};
    assign rd_ok  = is_open & {NUM_BANKS{rd_glob}};
    assign wr_ok  = is_open & {NUM_BANKS{wr_glob}};
    assign pre_ok = pre_rdy;

    // Legality of the presented command; unknown encodings are illegal
    always_comb begin
        bank_ok = (int'(cmd_bank) < NUM_BANKS);
        legal   = 1'b0;
        case (cmd_type)
            C_NOP, C_DES:  legal = 1'b1;
            C_ACT:         legal = bank_ok && act_ok[cmd_bank];
            C_RD:          legal = bank_ok && rd_ok[cmd_bank];
            C_WR:          legal = bank_ok && wr_ok[cmd_bank];
            C_PRE:         legal = bank_ok && pre_ok[cmd_bank];
            C_PREA:        legal = prea_ok;
            C_REF, C_MRS:  legal = ref_ok;
            default:       legal = 1'b0;
        endcase
    end

    // With no command presented there is nothing illegal to report
    assign cmd_legal = !cmd_valid || legal;
    assign acc       = cmd_valid && legal;
    assign bad       = cmd_valid && !legal;

    // Fan accepted commands out to the banks; PREA hits every open bank
    always_comb begin
        sel    = '0;
        do_act = '0;
        do_rd  = '0;
        do_wr  = '0;
        do_pre = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            sel[i]    = bank_ok && (int'(cmd_bank) == i);
            do_act[i] = acc && (cmd_type == C_ACT) && sel[i];
            do_rd[i]  = acc && (cmd_type == C_RD)  && sel[i];
            do_wr[i]  = acc && (cmd_type == C_WR)  && sel[i];
            do_pre[i] = acc && (((cmd_type == C_PRE) && sel[i]) ||
                                ((cmd_type == C_PREA) && is_open[i]));
        end
    end

    // Cross-bank timers; a load beats the decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trrd <= '0;
            tccd <= '0;
            twtr <= '0;
            trfc <= '0;
            tfaw <= '0;
        end else begin
            trrd <= dec(trrd);
            tccd <= dec(tccd);
            twtr <= dec(twtr);
            trfc <= dec(trfc);
            for (int s = 0; s < 4; s++) tfaw[s] <= dec(tfaw[s]);
            if (acc && cmd_type == C_ACT) begin
                trrd           <= L_RRD;
                tfaw[faw_slot] <= L_FAW;
            end
            if (acc && (cmd_type == C_RD || cmd_type == C_WR)) tccd <= L_CCD;
            if (acc && cmd_type == C_WR)  twtr <= L_WTR;
            if (acc && cmd_type == C_REF) trfc <= L_RFC;
        end
    end

    // Violation pulse and saturating violation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_o     <= 1'b0;
            viol_count <= '0;
        end else begin
            viol_o <= bad;
            if (bad && viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ddr_bank_ctx #(
            .ROW_W (ROW_W),
            .TW    (TW),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .T_RC  (T_RC),
            .T_CCD (T_CCD),
            .T_WR  (T_WR),
            .T_RTP (T_RTP)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .do_act   (do_act[b]),
            .do_rd    (do_rd[b]),
            .do_wr    (do_wr[b]),
            .do_pre   (do_pre[b]),
            .row      (cmd_row),
            .state    (bank_state_o[3*b +: 3]),
            .open_row (open_row_o[ROW_W*b +: ROW_W]),
            .act_rdy  (act_rdy[b]),
            .pre_rdy  (pre_rdy[b]),
            .is_open  (is_open[b]),
            .is_idle  (is_idle[b]),
            .is_actg  (is_actg[b])
        );
    end

endmodule

// File: tb/tb_ddr_bank_timing_tracker.sv
// Directed bench for ddr_bank_timing_tracker with default parameters.
// "Cycle N" is the cycle whose closing edge captures the command driven in it;
// registered outputs are read 1 time unit after the opening edge.
module tb_ddr_bank_timing_tracker;

    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PREA = 4'b1010;
    localparam logic [3:0] C_BAD  = 4'b1111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [3:0]   cmd_type = C_NOP;
    logic [2:0]   cmd_bank = '0;
    logic [16:0]  cmd_row = '0;
    logic         cmd_legal;
    logic [23:0]  bank_state_o;
    logic [135:0] open_row_o;
    logic [7:0]   act_ok, rd_ok, wr_ok, pre_ok;
    logic         ref_ok, viol_o;
    logic [15:0]  viol_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ddr_bank_timing_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_bank     (cmd_bank),
        .cmd_row      (cmd_row),
        .cmd_legal    (cmd_legal),
        .bank_state_o (bank_state_o),
        .open_row_o   (open_row_o),
        .act_ok       (act_ok),
        .rd_ok        (rd_ok),
        .wr_ok        (wr_ok),
        .pre_ok       (pre_ok),
        .ref_ok       (ref_ok),
        .viol_o       (viol_o),
        .viol_count   (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type  = C_NOP;
        cmd_bank  = '0;
        cmd_row   = '0;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic drive(input logic [3:0] t, input logic [2:0] b, input logic [16:0] r);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_bank  = b;
        cmd_row   = r;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = C_NOP;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // ---- reset values, ACT timing, early PRE, tRAS/tRP/tRC ----
        do_reset();
        chk("rst_state", bank_state_o, 24'h0);
        chk("rst_row", |open_row_o, 1'b0);
        chk("rst_act_ok", act_ok, 8'hFF);
        chk("rst_rd_ok", rd_ok, 8'h00);
        chk("rst_wr_ok", wr_ok, 8'h00);
        chk("rst_pre_ok", pre_ok, 8'h00);
        chk("rst_ref_ok", ref_ok, 1'b1);
        chk("rst_viol", viol_o, 1'b0);
        chk("rst_vcnt", viol_count, 16'd0);

        drive(C_ACT, 3'd0, 17'h1234);
        chk("act0_legal", cmd_legal, 1'b1);
        step();
        while (cyc < 18) begin
            chk("actg_state", bank_state_o[2:0], 3'b001);
            chk("actg_rd_ok", rd_ok[0], 1'b0);
            step();
        end
        chk("active_state", bank_state_o[2:0], 3'b010);
        chk("active_rd_ok", rd_ok[0], 1'b1);
        chk("open_row", open_row_o[16:0], 17'h1234);

        run_to(20);
        drive(C_PRE, 3'd0, '0);
        chk("pre_early_legal", cmd_legal, 1'b0);
        step();
        chk("pre_early_viol", viol_o, 1'b1);
        chk("pre_early_vcnt", viol_count, 16'd1);
        chk("pre_early_state", bank_state_o[2:0], 3'b010);
        step();
        chk("viol_pulse_end", viol_o, 1'b0);

        run_to(41);
        chk("pre_ok_41", pre_ok[0], 1'b0);
        step();
        chk("pre_ok_42", pre_ok[0], 1'b1);
        drive(C_PRE, 3'd0, '0);
        chk("pre_legal", cmd_legal, 1'b1);
        step();
        chk("prech_state", bank_state_o[2:0], 3'b101);
        run_to(59);
        chk("act_ok_59", act_ok[0], 1'b0);
        step();
        chk("act_ok_60", act_ok[0], 1'b1);
        chk("idle_60", bank_state_o[2:0], 3'b000);

        // ---- tRRD and tFAW ----
        do_reset();
        drive(C_ACT, 3'd0, 17'h1);
        chk("faw_act0", cmd_legal, 1'b1);
        step();
        run_to(7);
        chk("rrd_act_ok_7", act_ok[1], 1'b0);
        step();
        drive(C_ACT, 3'd1, 17'h2);
        chk("faw_act1", cmd_legal, 1'b1);
        step();
        run_to(16);
        drive(C_ACT, 3'd2, 17'h3);
        chk("faw_act2", cmd_legal, 1'b1);
        step();
        run_to(24);
        drive(C_ACT, 3'd3, 17'h4);
        chk("faw_act3", cmd_legal, 1'b1);
        step();
        run_to(32);
        drive(C_ACT, 3'd4, 17'h5);
        chk("faw_act4_32", cmd_legal, 1'b0);
        step();
        run_to(39);
        chk("faw_act_ok_39", act_ok[4], 1'b0);
        step();
        chk("faw_act_ok_40", act_ok[4], 1'b1);
        drive(C_ACT, 3'd4, 17'h5);
        chk("faw_act4_40", cmd_legal, 1'b1);
        step();
        chk("faw_bank4_state", bank_state_o[14:12], 3'b001);

        // ---- WR turnaround, REF/PREA/MRS, tRFC ----
        do_reset();
        drive(C_ACT, 3'd0, 17'h77);
        step();
        run_to(20);
        drive(C_WR, 3'd0, '0);
        chk("wr_legal", cmd_legal, 1'b1);
        step();
        chk("wr_state", bank_state_o[2:0], 3'b100);
        while (cyc < 28) begin
            chk("wtr_rd_ok", rd_ok[0], 1'b0);
            if (cyc == 23) chk("ccd_wr_ok_23", wr_ok[0], 1'b0);
            if (cyc == 24) begin
                chk("ccd_wr_ok_24", wr_ok[0], 1'b1);
                chk("burst_done_24", bank_state_o[2:0], 3'b010);
            end
            step();
        end
        chk("wtr_rd_ok_28", rd_ok[0], 1'b1);

        run_to(30);
        drive(C_REF, 3'd0, '0);
        chk("ref_open_legal", cmd_legal, 1'b0);
        step();
        chk("ref_open_vcnt", viol_count, 16'd1);

        run_to(41);
        chk("pre_ok_tras_41", pre_ok[0], 1'b0);
        step();
        chk("pre_ok_tras_42", pre_ok[0], 1'b1);
        drive(C_PREA, 3'd0, '0);
        chk("prea_legal", cmd_legal, 1'b1);
        step();
        chk("prea_state", bank_state_o[2:0], 3'b101);
        run_to(59);
        chk("ref_ok_59", ref_ok, 1'b0);
        step();
        chk("ref_ok_60", ref_ok, 1'b1);
        drive(C_REF, 3'd0, '0);
        chk("ref_legal", cmd_legal, 1'b1);
        step();
        chk("rfc_act_ok_61", act_ok, 8'h00);
        run_to(179);
        chk("rfc_act_ok_179", act_ok, 8'h00);
        step();
        chk("rfc_act_ok_180", act_ok, 8'hFF);
        drive(C_MRS, 3'd0, '0);
        chk("mrs_legal", cmd_legal, 1'b1);
        step();
        chk("mrs_no_timer", act_ok, 8'hFF);

        // ---- violation counter saturation ----
        do_reset();
        drive(C_BAD, 3'd0, '0);
        chk("undef_legal", cmd_legal, 1'b0);
        step();
        for (int i = 1; i < 65534; i++) begin
            drive(C_BAD, 3'd0, '0);
            step();
        end
        chk("vcnt_fffe", viol_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(C_BAD, 3'd0, '0);
            step();
        end
        chk("vcnt_sat", viol_count, 16'hFFFF);
        chk("sat_state", bank_state_o, 24'h0);

        // ---- asynchronous reset while ACTIVATING ----
        drive(C_ACT, 3'd0, 17'h1ABCD);
        step();
        step();
        step();
        chk("pre_rst_state", bank_state_o[2:0], 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", bank_state_o, 24'h0);
        chk("arst_row", |open_row_o, 1'b0);
        chk("arst_vcnt", viol_count, 16'd0);
        chk("arst_act_ok", act_ok, 8'hFF);
        chk("arst_rd_ok", rd_ok, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        drive(C_ACT, 3'd1, 17'h5);
        chk("post_rst_act", cmd_legal, 1'b1);
        step();
        chk("post_rst_state", bank_state_o[5:3], 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
